int_encoder: RTL and testbench
==============================

Name: int_encoder

Overview:
- Interrupt request encoder feeding CP0. The encoding counterpart of the one-hot decoder: it captures up to 8 external interrupt lines, masks them, and priority-encodes the winner into a source index.
- Runs a request/acknowledge/return handshake with the CPU core, so an interrupt is raised, taken, and retired exactly once.
- Sits between the external interrupt pins and the CP0/exception logic of the 54-instruction CPU.

Parameters:
- N_SRC, 8, number of interrupt sources. Fixed at 8 in this revision; the code width is log2(N_SRC).
- CODE_W, 3, width of oCode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- iReq  in  8  level interrupt lines, synchronous to clk. A rising edge latches a pending bit.
- iMask  in  8  Status.IM. A bit of 1 enables that source.
- iIE  in  1  Status.IE global enable.
- iExl  in  1  Status.EXL. While 1, new requests are blocked.
- iAck  in  1  one-cycle pulse: the core has taken the interrupt.
- iEret  in  1  one-cycle pulse: eret executed; ends service.
- iClr  in  8  software clear of pending bits (mtc0 Cause), one-cycle pulse per bit.
- oIrq  out  1  interrupt request to the core.
- oCode  out  3  index of the granted source.
- oPending  out  8  pending register, mirrored into Cause.IP.
- oBusy  out  1  1 while in SERVICE.

Behaviour:
- Reset (async, rst=1): req_q=0, pending=0, state=IDLE, oIrq=0, oCode=0, oPending=0, oBusy=0. Asserting rst mid-handshake aborts immediately; a subsequent iAck or iEret is ignored.
- Edge capture:
  - req_q <= iReq every cycle; edge = iReq & ~req_q.
  - pending_next = (pending & ~clr_mask) | edge.
  - clr_mask = iClr, OR the granted bit on an accepted iAck.
  - If set and clear hit the same bit in the same cycle, set wins.
  - A level held high sets the bit only once.
- Eligibility: elig = pending & iMask & {8{iIE & ~iExl}}.
- Priority: the highest index wins (bit 7 highest). win = index of the MSB set in elig.
- FSM states and transitions (all outputs are registered or decoded from the state register):
  - IDLE: if elig != 0, go to REQ and latch oCode = win. oIrq is high from the next cycle.
  - REQ:
    - oIrq = 1 and oCode is held stable; there is no preemption by a higher-priority source arriving here.
    - If iAck: clear pending[oCode] (unless re-set that cycle), go to SERVICE.
    - Otherwise, if elig[oCode] == 0 (masked, cleared by iClr, or iIE/iExl changed): withdraw to IDLE, with oIrq = 0 next cycle.
    - iAck wins over withdrawal in the same cycle.
  - SERVICE: oIrq = 0, oBusy = 1, oCode held. On iEret go to IDLE. Re-arbitration happens in IDLE on the following cycle.
- Ignored pulses:
  - iAck outside REQ is ignored.
  - iEret outside SERVICE is ignored.
  - iEret and iAck in the same cycle: only the one valid for the current state applies.
- Latency:
  - iReq rising at sample edge k: pending set after k; state REQ and oIrq = 1 after edge k+1.
  - Minimum gap between iEret and the next oIrq is 1 cycle (IDLE for 1 cycle).
- oPending always equals the pending register. It is not masked.

Test Plan:
- Reset: assert rst asynchronously with state in REQ, iReq=8'hFF → oIrq=0, oPending=0, oCode=0 immediately, without waiting for a clock edge.
- Single source:
  - Stimulus: iMask=8'hFF, iIE=1, iExl=0; iReq[2] rises at cycle 0.
  - Required: oPending=8'h04 after edge 0; oIrq=1, oCode=2 after edge 1.
  - Then iAck pulse → oPending=0, oBusy=1, oIrq=0.
  - Then iEret → oBusy=0.
- Priority and no preemption:
  - Stimulus: iReq[1] and iReq[5] rise together.
  - Required: oCode=5. Then iReq[7] rises while in REQ → oCode stays 5.
  - After iAck and iEret: oCode=7 two cycles after iEret, with oPending=8'h82.
- Mask and withdraw:
  - Stimulus: pending bit 3 only, state REQ; clear iMask[3].
  - Required: oIrq=0 next cycle, oPending=8'h08 retained.
  - Re-enable iMask[3] → oIrq=1 again with oCode=3.
- Same-cycle collision: in REQ with oCode=4, pulse iAck while iReq[4] rises (req_q[4]=0) → pending[4] stays 1, state SERVICE; after iEret it re-requests with oCode=4.
- Gating and spurious pulses:
  - iExl=1 with pending=8'h01 → oIrq stays 0 while pending stays visible.
  - Spurious iAck in IDLE and iEret in REQ → no state change.
  - iClr=8'h01 → oPending=0.

Source files
------------

// File: rtl/int_encoder.sv
// Interrupt request encoder feeding CP0.
// Captures rising edges on up to N_SRC interrupt lines into a pending
// register, masks them with Status.IM/IE/EXL, picks the highest-index
// eligible source and runs a request -> acknowledge -> eret handshake
// with the core, so each interrupt is raised, taken and retired once.
module int_encoder #(
    parameter int N_SRC  = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  iReq,
    input  logic [N_SRC-1:0]  iMask,
    input  logic              iIE,
    input  logic              iExl,
    input  logic              iAck,
    input  logic              iEret,
    input  logic [N_SRC-1:0]  iClr,
    output logic              oIrq,
    output logic [CODE_W-1:0] oCode,
    output logic [N_SRC-1:0]  oPending,
    output logic              oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    req_q;
    logic [N_SRC-1:0]    pending_q, pending_d;
    logic [CODE_W-1:0]   code_q, code_d;

    logic [N_SRC-1:0]    rise;
    logic [N_SRC-1:0]    elig;
    logic [N_SRC-1:0]    ack_mask;
    logic [CODE_W-1:0]   win;
    logic                ack_ok;

    assign rise   = iReq & ~req_q;
    assign elig   = pending_q & iMask & {N_SRC{iIE & ~iExl}};
    // An acknowledge only counts while a request is actually outstanding.
    assign ack_ok = (state_q == REQ) && iAck;

    // Priority encoder: the last (highest) set index seen overrides lower ones.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // otherwise paths that skip the assignment infer a latch.
        win = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (elig[i]) win = CODE_W'(i);
        end
    end

    // Pending update: clears first, then new edges, so a same-cycle set wins.
    always_comb begin
        ack_mask = '0;
        if (ack_ok) ack_mask[code_q] = 1'b1;
        pending_d = (pending_q & ~(iClr | ack_mask)) | rise;
    end

    // Handshake next-state logic; the granted code only changes on leaving IDLE.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    state_d = REQ;
                    code_d  = win;
                end
            end
            REQ: begin
                // Acknowledge beats withdrawal; no preemption while requesting.
                if (iAck)               state_d = SERVICE;
                else if (!elig[code_q]) state_d = IDLE;
            end
            SERVICE: begin
                if (iEret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge-capture and pending registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= iReq;
            pending_q <= pending_d;
            code_q    <= code_d;
        end
    end

    assign oIrq     = (state_q == REQ);
    assign oBusy    = (state_q == SERVICE);
    assign oCode    = code_q;
    assign oPending = pending_q;

endmodule

// File: tb/tb_int_encoder.sv
// Self-checking bench for int_encoder: directed handshake scenarios with
// literal expectations, plus a behavioural model compared every cycle.
module tb_int_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] iReq;
    logic [7:0] iMask;
    logic       iIE;
    logic       iExl;
    logic       iAck;
    logic       iEret;
    logic [7:0] iClr;
    logic       oIrq;
    logic [2:0] oCode;
    logic [7:0] oPending;
    logic       oBusy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    int_encoder #(.N_SRC(8), .CODE_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iMask    (iMask),
        .iIE      (iIE),
        .iExl     (iExl),
        .iAck     (iAck),
        .iEret    (iEret),
        .iClr     (iClr),
        .oIrq     (oIrq),
        .oCode    (oCode),
        .oPending (oPending),
        .oBusy    (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nothing raised, 1 = interrupt raised to core, 2 = being serviced
    int         m_phase;
    logic [7:0] m_prev_req;
    logic [7:0] m_pend;
    int         m_code;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase    = 0;
            m_prev_req = 8'h00;
            m_pend     = 8'h00;
            m_code     = 0;
        end else begin
            logic [7:0] allowed, rise, next_pend;
            allowed   = (iIE && !iExl) ? (m_pend & iMask) : 8'h00;
            rise      = iReq & ~m_prev_req;
            next_pend = m_pend & ~iClr;
            if (m_phase == 1 && iAck) next_pend[m_code] = 1'b0;
            next_pend = next_pend | rise;
            if (m_phase == 0) begin
                if (allowed != 8'h00) begin
                    for (int i = 7; i >= 0; i--) begin
                        if (allowed[i]) begin
                            m_code = i;
                            break;
                        end
                    end
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (iAck)                  m_phase = 2;
                else if (!allowed[m_code]) m_phase = 0;
            end else begin
                if (iEret) m_phase = 0;
            end
            m_pend     = next_pend;
            m_prev_req = iReq;
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("model_irq",     8'(oIrq),     (m_phase == 1) ? 8'h01 : 8'h00);
            check("model_busy",    8'(oBusy),    (m_phase == 2) ? 8'h01 : 8'h00);
            check("model_code",    8'(oCode),    8'(m_code));
            check("model_pending", oPending,     m_pend);
        end
    end

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        iReq  = 8'h00;
        iMask = 8'hFF;
        iIE   = 1'b1;
        iExl  = 1'b0;
        iAck  = 1'b0;
        iEret = 1'b0;
        iClr  = 8'h00;
        #3;
        check("reset_irq",     8'(oIrq),  8'h00);
        check("reset_code",    8'(oCode), 8'h00);
        check("reset_pending", oPending,  8'h00);
        check("reset_busy",    8'(oBusy), 8'h00);
        rst    = 1'b0;
        cmp_en = 1'b1;
        tick();

        // ---- single source ----
        iReq = 8'h04;
        tick();
        check("single_pending", oPending, 8'h04);
        check("single_irq_lat", 8'(oIrq), 8'h00);
        tick();
        check("single_irq",  8'(oIrq),  8'h01);
        check("single_code", 8'(oCode), 8'h02);
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        iReq = 8'h00;
        check("single_ack_pending", oPending,  8'h00);
        check("single_ack_busy",    8'(oBusy), 8'h01);
        check("single_ack_irq",     8'(oIrq),  8'h00);
        iEret = 1'b1;
        tick();
        iEret = 1'b0;
        check("single_eret_busy", 8'(oBusy), 8'h00);

        // ---- priority and no preemption ----
        iReq = 8'h22;
        tick();
        tick();
        check("prio_code", 8'(oCode), 8'h05);
        iReq = 8'hA2;
        tick();
        check("prio_nopreempt_code", 8'(oCode), 8'h05);
        check("prio_nopreempt_irq",  8'(oIrq),  8'h01);
        check("prio_pending",        oPending,  8'hA2);
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        iReq = 8'h00;
        check("prio_ack_pending", oPending, 8'h82);
        iEret = 1'b1;
        tick();
        iEret = 1'b0;
        check("prio_eret_idle", 8'(oIrq), 8'h00);
        tick();
        check("prio_rearb_irq",     8'(oIrq),  8'h01);
        check("prio_rearb_code",    8'(oCode), 8'h07);
        check("prio_rearb_pending", oPending,  8'h82);
        iClr = 8'hFF;
        tick();
        iClr = 8'h00;
        check("clr_all_pending", oPending, 8'h00);
        tick();
        check("clr_withdraw_irq", 8'(oIrq), 8'h00);

        // ---- mask and withdraw ----
        iReq = 8'h08;
        tick();
        tick();
        check("mask_req_code", 8'(oCode), 8'h03);
        iMask = 8'hF7;
        tick();
        check("mask_withdraw_irq", 8'(oIrq), 8'h00);
        check("mask_keep_pending", oPending, 8'h08);
        iMask = 8'hFF;
        tick();
        check("mask_reenable_irq",  8'(oIrq),  8'h01);
        check("mask_reenable_code", 8'(oCode), 8'h03);
        iReq = 8'h00;
        iAck = 1'b1;
        tick();
        iAck  = 1'b0;
        iEret = 1'b1;
        tick();
        iEret = 1'b0;

        // ---- same-cycle set/clear collision ----
        iReq = 8'h10;
        tick();
        iReq = 8'h00;
        tick();
        check("coll_code", 8'(oCode), 8'h04);
        iAck = 1'b1;
        iReq = 8'h10;
        tick();
        iAck = 1'b0;
        check("coll_pending", oPending,  8'h10);
        check("coll_busy",    8'(oBusy), 8'h01);
        iEret = 1'b1;
        tick();
        iEret = 1'b0;
        tick();
        check("coll_rereq_irq",  8'(oIrq),  8'h01);
        check("coll_rereq_code", 8'(oCode), 8'h04);
        iAck = 1'b1;
        tick();
        iAck  = 1'b0;
        iEret = 1'b1;
        tick();
        iEret = 1'b0;
        iReq  = 8'h00;
        tick();

        // ---- gating and spurious pulses ----
        iExl = 1'b1;
        iReq = 8'h01;
        tick();
        iReq = 8'h00;
        tick();
        tick();
        check("exl_irq",     8'(oIrq), 8'h00);
        check("exl_pending", oPending, 8'h01);
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        check("spur_ack_busy",    8'(oBusy), 8'h00);
        check("spur_ack_pending", oPending,  8'h01);
        iExl = 1'b0;
        tick();
        check("exl_release_irq",  8'(oIrq),  8'h01);
        check("exl_release_code", 8'(oCode), 8'h00);
        iEret = 1'b1;
        tick();
        iEret = 1'b0;
        check("spur_eret_irq",  8'(oIrq),  8'h01);
        check("spur_eret_busy", 8'(oBusy), 8'h00);
        iClr = 8'h01;
        tick();
        iClr = 8'h00;
        check("clr_pending", oPending, 8'h00);
        tick();
        check("clr_withdraw", 8'(oIrq), 8'h00);

        // ---- asynchronous reset mid-handshake ----
        iReq = 8'h40;
        tick();
        tick();
        check("prereset_irq",  8'(oIrq),  8'h01);
        check("prereset_code", 8'(oCode), 8'h06);
        iReq = 8'hFF;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_irq",     8'(oIrq),  8'h00);
        check("async_rst_code",    8'(oCode), 8'h00);
        check("async_rst_pending", oPending,  8'h00);
        iReq = 8'h00;
        tick();
        rst   = 1'b0;
        iAck  = 1'b1;
        iEret = 1'b1;
        tick();
        iAck  = 1'b0;
        iEret = 1'b0;
        check("postrst_busy",    8'(oBusy), 8'h00);
        check("postrst_irq",     8'(oIrq),  8'h00);
        check("postrst_pending", oPending,  8'h00);
        tick();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
